// File: rtl/vend_pkg.sv
// Shared coin-interface definitions: coin codes, coin values and the payout FSM states.
// The coin codes are common to the coin-input and payout paths.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_GAP,
        ST_FAULT
    } disp_state_t;

endpackage

// File: rtl/ack_timer.sv
// Wait counter for the hopper acknowledge: cleared before each coin, counts while enabled.
// expired is high during the ACK_TIMEOUT-th cycle that the counter has been enabled.
module ack_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Count value k means the current cycle is the (k+1)-th one waited.
    assign expired = (cnt == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Payout FSM: pays a change amount greedily in 10/5 coins through the hopper,
// falling back to 5s when the 10 tube is empty, with a sticky fault on ack timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request
// ST_SELECT | pick next coin, finish (done) or fault on empty tubes
// ST_ISSUE  | coin_valid high, waiting for coin_ack or timeout
// ST_GAP    | one idle cycle between coins
// ST_FAULT  | hopper fault, held until reset
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 6,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             empty10,
    input  logic             empty5,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    output logic             done,
    output logic [AMT_W-1:0] residue,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);

    disp_state_t      state, state_next;
    logic             load_req;
    logic             set_coin;
    logic [1:0]       coin_sel;
    logic             clr_coin;
    logic             pay;
    logic             timer_clr;
    logic             expired;
    logic [AMT_W-1:0] amt_mod5;
    logic [AMT_W-1:0] coin_amt;

    ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clr),
        .en      (state == ST_ISSUE),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        set_coin   = 1'b0;
        coin_sel   = COIN_NONE;
        clr_coin   = 1'b0;
        pay        = 1'b0;
        timer_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    load_req   = 1'b1;
                    state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                timer_clr = 1'b1;
                // remaining is always a multiple of 5, so nonzero implies >= 5
                if (remaining == '0) begin
                    state_next = ST_IDLE;
                end else if (remaining >= AMT_W'(VAL_10) && !empty10) begin
                    set_coin   = 1'b1;
                    coin_sel   = COIN_10;
                    state_next = ST_ISSUE;
                end else if (!empty5) begin
                    set_coin   = 1'b1;
                    coin_sel   = COIN_5;
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (coin_ack) begin
                    pay        = 1'b1;
                    clr_coin   = 1'b1;
                    state_next = ST_GAP;
                end else if (expired) begin
                    clr_coin   = 1'b1;
                    state_next = ST_FAULT;
                end
            end
            ST_GAP:   state_next = ST_SELECT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign amt_mod5 = req_amount % AMT_W'(VAL_5);
    assign coin_amt = (coin_out == COIN_10) ? AMT_W'(VAL_10) : AMT_W'(VAL_5);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            residue   <= '0;
            coin_out  <= COIN_NONE;
        end else begin
            if (load_req) begin
                remaining <= req_amount - amt_mod5;
                residue   <= amt_mod5;
            end else if (pay) begin
                remaining <= remaining - coin_amt;
            end
            if (set_coin) begin
                coin_out <= coin_sel;
            end else if (clr_coin) begin
                coin_out <= COIN_NONE;
            end
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign coin_valid = (state == ST_ISSUE);
    assign done       = (state == ST_SELECT) && (remaining == '0);
    assign fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected coins and residues,
// a negedge monitor pops and compares them as coins and done pulses appear.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic [5:0] req_amount = '0;
    logic       req_ready;
    logic       empty10 = 1'b0;
    logic       empty5 = 1'b0;
    logic [1:0] coin_out;
    logic       coin_valid;
    logic       coin_ack = 1'b0;
    logic       done;
    logic [5:0] residue;
    logic       fault;
    logic [5:0] remaining;

    change_dispenser #(
        .AMT_W(6),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .empty10    (empty10),
        .empty5     (empty5),
        .coin_out   (coin_out),
        .coin_valid (coin_valid),
        .coin_ack   (coin_ack),
        .done       (done),
        .residue    (residue),
        .fault      (fault),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    logic [1:0] exp_coin[$];
    logic [5:0] exp_res[$];

    bit         ack_mode = 1'b1;
    int         hop_cnt = 0;
    int         coins_seen = 0;
    int         valid_run = 0;
    int         last_run = 0;
    int         low_run = 0;
    logic       prev_valid = 1'b0;
    logic [1:0] cur_coin = 2'b00;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Hopper model: acks on the 2nd low-phase sample of coin_valid when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (coin_valid && ack_mode) begin
                hop_cnt++;
                coin_ack = (hop_cnt >= 2);
            end else begin
                hop_cnt  = 0;
                coin_ack = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 1'b0;
                valid_run  = 0;
                low_run    = 0;
            end else begin
                if (coin_valid) begin
                    if (!prev_valid) begin
                        coins_seen++;
                        chk("coin_gap", int'(low_run >= 2), 1);
                        if (exp_coin.size() == 0) fail_now("unexpected_coin");
                        else chk("coin_out", int'(coin_out), int'(exp_coin.pop_front()));
                        cur_coin = coin_out;
                    end else begin
                        chk("coin_hold", int'(coin_out), int'(cur_coin));
                    end
                    valid_run++;
                    low_run = 0;
                end else begin
                    if (prev_valid) last_run = valid_run;
                    valid_run = 0;
                    low_run++;
                    chk("coin_out_idle", int'(coin_out), 0);
                end
                if (done) begin
                    if (exp_res.size() == 0) fail_now("unexpected_done");
                    else chk("residue", int'(residue), int'(exp_res.pop_front()));
                    chk("fault_at_done", int'(fault), 0);
                end
                prev_valid = coin_valid;
            end
        end
    end

    task automatic send(input logic [5:0] amt);
        @(negedge clk);
        chk("req_ready_before_req", int'(req_ready), 1);
        req_valid  = 1'b1;
        req_amount = amt;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) fail_now(name);
    endtask

    initial begin
        int  base;
        bit  seen;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_coin_valid", int'(coin_valid), 0);
        chk("rst_coin_out", int'(coin_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_residue", int'(residue), 0);
        chk("rst_remaining", int'(remaining), 0);
        reset = 1'b1;

        // 25: 10, 10, 5
        exp_coin.push_back(2'b10);
        exp_coin.push_back(2'b10);
        exp_coin.push_back(2'b01);
        exp_res.push_back(6'd0);
        send(6'd25);
        wait_done("done_25");
        chk("coins_25", coins_seen, 3);

        // 0: done in the cycle after acceptance, no coins
        base = coins_seen;
        exp_res.push_back(6'd0);
        send(6'd0);
        chk("zero_done", int'(done), 1);
        chk("zero_ready_low", int'(req_ready), 0);
        @(negedge clk);
        chk("zero_ready_back", int'(req_ready), 1);
        chk("zero_done_gone", int'(done), 0);
        chk("zero_no_coin", coins_seen, base);

        // 3: treated as zero, residue 3
        exp_res.push_back(6'd3);
        send(6'd3);
        chk("three_done", int'(done), 1);

        // 23: 10, 10, residue 3
        base = coins_seen;
        exp_coin.push_back(2'b10);
        exp_coin.push_back(2'b10);
        exp_res.push_back(6'd3);
        send(6'd23);
        wait_done("done_23");
        chk("coins_23", coins_seen - base, 2);

        // 20 with the 10 tube empty: four 5s
        base = coins_seen;
        empty10 = 1'b1;
        repeat (4) exp_coin.push_back(2'b01);
        exp_res.push_back(6'd0);
        send(6'd20);
        wait_done("done_20_empty10");
        chk("coins_20_empty10", coins_seen - base, 4);
        empty10 = 1'b0;

        // 15 with no acks: timeout, fault with remaining frozen
        ack_mode = 1'b0;
        exp_coin.push_back(2'b10);
        send(6'd15);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (fault) seen = 1'b1;
        end
        if (!seen) fail_now("fault_timeout");
        @(negedge clk);
        chk("timeout_valid_cycles", last_run, 15);
        chk("fault_remaining", int'(remaining), 15);
        chk("fault_coin_valid", int'(coin_valid), 0);
        chk("fault_req_ready", int'(req_ready), 0);
        repeat (5) @(negedge clk);
        chk("fault_sticky", int'(fault), 1);
        chk("fault_remaining_held", int'(remaining), 15);
        chk("fault_ready_held", int'(req_ready), 0);
        ack_mode = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        chk("fault_cleared", int'(fault), 0);
        reset = 1'b1;

        // 30 with async reset during the second coin
        base = coins_seen;
        exp_coin.push_back(2'b10);
        exp_coin.push_back(2'b10);
        send(6'd30);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (coins_seen >= base + 2) seen = 1'b1;
        end
        if (!seen) fail_now("second_coin_wait");
        #2;
        chk("mid_in_issue", int'(coin_valid), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_coin_valid", int'(coin_valid), 0);
        chk("mid_rst_coin_out", int'(coin_out), 0);
        chk("mid_rst_req_ready", int'(req_ready), 1);
        chk("mid_rst_remaining", int'(remaining), 0);
        chk("mid_rst_residue", int'(residue), 0);
        chk("mid_rst_fault", int'(fault), 0);
        chk("mid_rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("queue_drained_at_reset", exp_coin.size(), 0);

        // 10 after release: a single 10 coin
        base = coins_seen;
        exp_coin.push_back(2'b10);
        exp_res.push_back(6'd0);
        send(6'd10);
        wait_done("done_10_after_reset");
        chk("coins_10", coins_seen - base, 1);

        repeat (3) @(negedge clk);
        chk("final_coin_queue", exp_coin.size(), 0);
        chk("final_res_queue", exp_res.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
